// File: rtl/serial_sort_engine_if.sv
// Stream bundle for the serial sort engine: unsorted keys in, sorted keys out.
// The master side is the producer/consumer pair, the slave side is the engine.
interface serial_sort_engine_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_last;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid, out_last
  );
endinterface

// File: rtl/serial_sort_engine.sv
// Streaming insertion sorter: DEPTH compare/shift cells keep the frame sorted
// as keys arrive; cell 0 is always the head and is streamed out while draining.
module serial_sort_engine #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int CW         = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  descending,
  serial_sort_engine_if.slave   bus,
  output logic [CW-1:0]         count,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                state_r;
  state_t                nxt_state_s;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         nxt_count_s;
  logic                  order_r;
  logic                  ready_r;
  logic                  out_valid_r;
  logic                  out_last_r;
  logic                  busy_r;
  logic                  ready_nxt_s;
  logic                  valid_nxt_s;
  logic                  last_nxt_s;
  logic                  busy_nxt_s;

  logic [DATA_WIDTH-1:0] key_r [DEPTH];
  logic [DEPTH-1:0]      vld_r;

  logic                  accept_s;
  logic                  xfer_s;
  logic                  ord_s;
  logic [DEPTH-1:0]      move_s;
  logic [DEPTH-1:0]      move_dn_s;
  logic [DEPTH-1:0]      vld_dn_s;
  logic [DEPTH-1:0]      vld_up_s;
  logic [DEPTH*DATA_WIDTH-1:0] key_flat_s;
  logic [DEPTH*DATA_WIDTH-1:0] key_dn_s;
  logic [DEPTH*DATA_WIDTH-1:0] key_up_s;

  assign accept_s = bus.in_valid && ready_r;
  assign xfer_s   = out_valid_r && bus.out_ready;

  // The order register is only meaningful once a frame has started; the
  // very first key of a frame lands in an empty array, so the live input is used.
  assign ord_s = (state_r == IDLE) ? descending : order_r;

  // Neighbour views of the cell array: *_dn_s is what cell i sees from cell
  // i-1 (shift toward tail), *_up_s from cell i+1 (shift toward head).
  assign move_dn_s = {move_s[DEPTH-2:0], 1'b0};
  assign vld_dn_s  = {vld_r[DEPTH-2:0], 1'b1};
  assign vld_up_s  = {1'b0, vld_r[DEPTH-1:1]};
  assign key_dn_s  = {key_flat_s[(DEPTH-1)*DATA_WIDTH-1:0], {DATA_WIDTH{1'b0}}};
  assign key_up_s  = {{DATA_WIDTH{1'b0}}, key_flat_s[DEPTH*DATA_WIDTH-1:DATA_WIDTH]};

  // Flatten the cell keys so neighbour selects never index outside the array.
  always_comb begin
    key_flat_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      key_flat_s[i*DATA_WIDTH +: DATA_WIDTH] = key_r[i];
    end
  end

  // Per-cell compare: a valid cell that must make room for the new key.
  // Strict comparison places equal keys behind earlier arrivals (stable).
  always_comb begin
    move_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_r[i]) begin
        if (ord_s) begin
          move_s[i] = key_r[i] < bus.in_data;
        end else begin
          move_s[i] = key_r[i] > bus.in_data;
        end
      end else begin
        move_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic for the frame lifecycle.
  always_comb begin
    nxt_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          if (bus.in_last) begin
            nxt_state_s = DRAIN;
          end else begin
            nxt_state_s = LOAD;
          end
        end else begin
          nxt_state_s = IDLE;
        end
      end
      LOAD: begin
        if (accept_s && (bus.in_last || (count_r == CW'(DEPTH - 1)))) begin
          nxt_state_s = DRAIN;
        end else begin
          nxt_state_s = LOAD;
        end
      end
      DRAIN: begin
        if (xfer_s && (count_r == CW'(1))) begin
          nxt_state_s = IDLE;
        end else begin
          nxt_state_s = DRAIN;
        end
      end
      default: nxt_state_s = IDLE;
    endcase
  end

  // Output decode: next values of the registered status/handshake outputs.
  always_comb begin
    nxt_count_s = count_r;
    if (accept_s) begin
      nxt_count_s = count_r + CW'(1);
    end else if (xfer_s) begin
      nxt_count_s = count_r - CW'(1);
    end else begin
      nxt_count_s = count_r;
    end
    ready_nxt_s = (nxt_state_s != DRAIN);
    valid_nxt_s = (nxt_state_s == DRAIN);
    last_nxt_s  = (nxt_state_s == DRAIN) && (nxt_count_s == CW'(1));
    busy_nxt_s  = (nxt_state_s != IDLE);
  end

  // State, count, order and registered outputs; reset outranks flush.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      state_r     <= IDLE;
      count_r     <= '0;
      order_r     <= 1'b0;
      ready_r     <= 1'b0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= nxt_state_s;
      count_r     <= nxt_count_s;
      ready_r     <= ready_nxt_s;
      out_valid_r <= valid_nxt_s;
      out_last_r  <= last_nxt_s;
      busy_r      <= busy_nxt_s;
      if ((state_r == IDLE) && accept_s) begin
        order_r <= descending;
      end
    end
  end

  // Cell array: insert with shift toward tail on accept, shift toward head on transfer.
  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_r[i] <= '0;
      end
      vld_r <= '0;
    end else if (accept_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (move_dn_s[i]) begin
          key_r[i] <= key_dn_s[i*DATA_WIDTH +: DATA_WIDTH];
          vld_r[i] <= 1'b1;
        end else if (move_s[i]) begin
          key_r[i] <= bus.in_data;
        end else if (!vld_r[i] && vld_dn_s[i]) begin
          key_r[i] <= bus.in_data;
          vld_r[i] <= 1'b1;
        end
      end
    end else if (xfer_s) begin
      for (int i = 0; i < DEPTH; i++) begin
        key_r[i] <= key_up_s[i*DATA_WIDTH +: DATA_WIDTH];
        vld_r[i] <= vld_up_s[i];
      end
    end
  end

  assign bus.in_ready  = ready_r;
  assign bus.out_data  = key_r[0];
  assign bus.out_valid = out_valid_r;
  assign bus.out_last  = out_last_r;
  assign count         = count_r;
  assign busy          = busy_r;

endmodule

// File: tb/tb_serial_sort_engine.sv
// Directed and randomized frames checked against a queue-sort reference model.
module tb_serial_sort_engine;
  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          flush;
  logic          descending;
  logic [CW-1:0] count;
  logic          busy;

  int tests = 0;
  int fails = 0;
  int frame_q[$];
  int exp_q[$];

  serial_sort_engine_if #(.DATA_WIDTH(DW)) bus ();

  serial_sort_engine #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .descending (descending),
    .bus        (bus),
    .count      (count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: the frame sorted by key in the requested order.
  task automatic build_expected(input bit desc);
    exp_q = frame_q;
    if (desc) exp_q.rsort();
    else      exp_q.sort();
  endtask

  task automatic push(input logic [DW-1:0] k, input bit last, input bit desc);
    int t = 0;
    bus.in_data  = k;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    descending   = desc;
    while (!bus.in_ready && t < 50) begin
      tick();
      t++;
    end
    check("push_timeout", 32'(t < 50), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Sends frame_q; descending flips after the first key to prove it is ignored.
  task automatic send(input bit desc, input bit mark_last);
    int n = frame_q.size();
    for (int i = 0; i < n; i++) begin
      push(DW'(frame_q[i]), mark_last && (i == n - 1), (i == 0) ? desc : !desc);
      check("load_count", 32'(count), 32'(i + 1));
    end
    build_expected(desc);
  endtask

  task automatic drain(input bit rnd_rdy);
    int n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check("out_valid", 32'(bus.out_valid), 32'd1);
      check("out_data", 32'(bus.out_data), 32'(exp_q[i]));
      check("out_last", 32'(bus.out_last), 32'(i == n - 1));
      check("drain_count", 32'(count), 32'(n - i));
      check("drain_in_ready", 32'(bus.in_ready), 32'd0);
      if (rnd_rdy) begin
        int s = int'($urandom_range(0, 2));
        repeat (s) begin
          tick();
          check("stall_data", 32'(bus.out_data), 32'(exp_q[i]));
          check("stall_last", 32'(bus.out_last), 32'(i == n - 1));
          check("stall_count", 32'(count), 32'(n - i));
        end
      end
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
    end
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);
    check("idle_count", 32'(count), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_out_last"}, 32'(bus.out_last), 32'd0);
    check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    check({tag, "_count"}, 32'(count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset         = 1'b0;
    flush         = 1'b0;
    descending    = 1'b0;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b1;
    tick();
    check("release_in_ready", 32'(bus.in_ready), 32'd1);

    // in_last without in_valid must not start a frame
    bus.in_last = 1'b1;
    tick();
    bus.in_last = 1'b0;
    check("orphan_last_busy", 32'(busy), 32'd0);
    check("orphan_last_count", 32'(count), 32'd0);

    // Ascending frame, back-to-back
    frame_q = {5, 3, 9, 1};
    send(1'b0, 1'b1);
    check("asc_busy", 32'(busy), 32'd1);
    drain(1'b0);

    // Descending with duplicates
    frame_q = {4, 7, 4, 2};
    send(1'b1, 1'b1);
    drain(1'b0);

    // Truncation: eight keys without in_last, ninth held by the producer
    frame_q = {8, 7, 6, 5, 4, 3, 2, 1};
    send(1'b0, 1'b0);
    check("trunc_in_ready", 32'(bus.in_ready), 32'd0);
    check("trunc_out_valid", 32'(bus.out_valid), 32'd1);
    bus.in_data  = 8'd0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    drain(1'b0);
    frame_q = {0};
    send(1'b0, 1'b1);
    drain(1'b0);

    // Backpressure
    frame_q = {6, 2, 6, 1};
    send(1'b0, 1'b1);
    drain(1'b1);

    // Flush mid-LOAD
    frame_q = {5, 9, 3};
    send(1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_reset_values("flush_load");

    // Flush mid-DRAIN after one transfer
    frame_q = {4, 8, 6, 7};
    send(1'b0, 1'b1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check("flush_pre_data", 32'(bus.out_data), 32'd6);
    check("flush_pre_count", 32'(count), 32'd3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_reset_values("flush_drain");
    frame_q = {2, 1};
    send(1'b0, 1'b1);
    drain(1'b0);

    // Reset pulse during DRAIN
    frame_q = {30, 10, 20};
    send(1'b0, 1'b1);
    check("rst_pre_data", 32'(bus.out_data), 32'd10);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_reset_values("reset_drain");
    frame_q = {42};
    send(1'b0, 1'b1);
    drain(1'b0);

    // Randomized frames
    for (int f = 0; f < 16; f++) begin
      int n = int'($urandom_range(1, DEPTH));
      bit desc = 1'($urandom_range(0, 1));
      frame_q = {};
      for (int k = 0; k < n; k++) begin
        frame_q.push_back(int'($urandom_range(0, (f % 2 == 1) ? 255 : 15)));
      end
      send(desc, 1'b1);
      drain(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_sort_engine.md
# serial_sort_engine

Parametrised streaming insertion sorter: a linear array of DEPTH compare/shift cells that sorts one frame of up to DEPTH keys as they arrive, one per cycle, then streams them out in sorted order. It generalises the fixed serial sort chain with parametrised depth, run-time ascending/descending order, valid/ready handshakes on both sides, explicit frame framing and flush. It sits between an unsorted producer stream and a sorted consumer stream in the datapath.

## Interface
- DATA_WIDTH, 8, key width in bits
- DEPTH, 8, number of sort cells (maximum frame length); legal range 2..256
- clk  input  1  single clock, rising edge
- reset  input  1  synchronous, active-low; clears all state
- flush  input  1  synchronous clear of the current frame, same effect as reset
- descending  input  1  sort order for the frame: 0 ascending, 1 descending; sampled on the first accepted element of a frame
- in_data  input  DATA_WIDTH  unsorted key
- in_valid  input  1  in_data valid
- in_last  input  1  marks final key of the frame; qualified by in_valid
- in_ready  output  1  engine accepts in_data this cycle
- out_data  output  DATA_WIDTH  sorted key (head cell)
- out_valid  output  1  out_data valid
- out_last  output  1  final key of the frame
- out_ready  input  1  consumer accepts out_data
- count  output  $clog2(DEPTH+1)  number of keys held
- busy  output  1  high in LOAD or DRAIN

## Operation
- States: IDLE, LOAD, DRAIN. Reset/flush -> IDLE, count=0, all cells invalid, order register=0.
- Accept = in_valid && in_ready. in_ready=1 in IDLE and LOAD, 0 in DRAIN.
- IDLE: accept -> latch descending into order register, insert key, go LOAD (or DRAIN if in_last or DEPTH reached).
- LOAD: each accept inserts one key in one cycle, count++. Transition to DRAIN after accept with in_last=1, or after the accept that makes count==DEPTH (frame truncated; following keys belong to next frame).
- Insertion (ascending): each valid cell whose key is strictly greater than the new key shifts its key one cell toward the tail; the first such cell takes the new key; if none, the new key goes into the first invalid cell. Descending uses strictly-less. Equal keys keep arrival order (stable).
- Cell 0 always holds the head (min ascending / max descending).
- DRAIN: out_valid=1, out_data=cell0. Transfer = out_valid && out_ready: all cells shift one toward head, tail cell becomes invalid, count--. out_last=1 when count==1. Transfer with out_last -> IDLE.
- flush overrides all other inputs in any state; reset has priority over flush.

## Timing
- Reset values: in_ready=0 while reset asserted, 1 the cycle after release; out_valid=0, out_last=0, out_data=0, count=0, busy=0.
- Insert latency: key visible in cell array and count updated the cycle after accept.
- Load-to-drain: accept of last key at cycle N -> out_valid=1 at N+1, out_data = head of fully sorted frame.
- Drain throughput: one key per cycle with out_ready held high; frame of n keys drains in n cycles.
- DRAIN -> IDLE: in_ready=1 the cycle after the out_last transfer; no input overlap with drain.
- out_data/out_last stable while out_valid && !out_ready.
- descending changes mid-frame are ignored.
- in_last with in_valid=0 is ignored.

## Test plan
- Ascending, DEPTH=8: send 5,3,9,1 (last on 1) back-to-back -> out 1,3,5,9, out_last on 9, out_valid first cycle after last accept, in_ready=1 one cycle after 9 transfers.
- Descending with duplicates: 4,7,4,2 last, descending=1 -> out 7,4,4,2, duplicates in arrival order (tag via testbench shadow).
- Truncation: 9 keys 8..0 without in_last, DEPTH=8 -> DRAIN after 8th key, in_ready=0; out 1..8 with out_last on 8; 9th key (0) held by producer, accepted as new single-key frame and output alone with out_last.
- Backpressure: random out_ready during drain of 6,2,6,1 -> out 1,2,6,6, out_data held steady during stalls, count decrements only on transfers.
- Flush mid-LOAD after 3 keys and mid-DRAIN after 1 transfer -> next cycle IDLE, count=0, out_valid=0; following frame 2,1 sorts to 1,2.
- Reset low for one cycle during DRAIN -> all outputs at reset values next cycle; single-key frame 42 with in_last -> out 42, out_last=1.
